// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle control FSM and the RV32I datapath.
// The FSM side (master) consumes decode/branch/halt status and drives all strobes and selects.
interface multicycle_control_fsm_if;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       halt_req;
  logic       pc_write;
  logic       pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       halted;

  modport master (
    input  opcode, alu_bcond, halt_req,
    output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, halted
  );

  modport slave (
    output opcode, alu_bcond, halt_req,
    input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, halted
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB,
// holding IF and MEM for MEM_LAT cycles, and decodes strobes from state + opcode.
module multicycle_control_fsm #(
  parameter int MEM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_fsm_if.master    bus
);
  localparam logic [6:0] OP_ARITH   = 7'b0110011;
  localparam logic [6:0] OP_ARITHI  = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_ECALL   = 7'b1110011;
  localparam logic [3:0] LAST_CNT   = 4'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_PCINC, S_HALT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       halted_q;
  logic       last;

  logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op;

  assign last = (cnt_q == LAST_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IF;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_q == S_HALT);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (last) begin
          ir_write = 1'b1;
          state_d  = S_ID;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_ID: begin
        alu_src_b = 2'b10;
        state_d   = S_EX;
      end
      S_EX: begin
        case (bus.opcode)
          OP_ARITH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_ARITHI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
            state_d   = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            if (bus.alu_bcond) begin
              // Target was parked in ALUOut during ID.
              pc_write  = 1'b1;
              pc_source = 1'b1;
              state_d   = S_IF;
            end else begin
              state_d = S_PCINC;
            end
          end
          OP_JAL: begin
            pc_write  = 1'b1;
            pc_source = 1'b1;
            alu_src_b = 2'b01;
            state_d   = S_WB;
          end
          OP_JALR: begin
            alu_src_b = 2'b01;
            state_d   = S_WB;
          end
          OP_ECALL: state_d = bus.halt_req ? S_HALT : S_PCINC;
          default:  state_d = S_PCINC;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (bus.opcode == OP_STORE) begin
          if (last) begin
            mem_write = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            state_d   = S_IF;
          end
        end else begin
          mem_read = 1'b1;
          if (last) state_d = S_WB;
        end
        if (!last) cnt_d = cnt_q + 4'd1;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (bus.opcode == OP_LOAD);
        state_d    = S_IF;
        if (bus.opcode == OP_JALR) begin
          // rs1 is consumed here before rd is written, so rd==rs1 is safe.
          pc_write  = 1'b1;
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end else if (bus.opcode != OP_JAL) begin
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
      end
      S_PCINC: begin
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  assign bus.pc_write   = pc_write   & ~reset;
  assign bus.pc_source  = pc_source  & ~reset;
  assign bus.i_or_d     = i_or_d     & ~reset;
  assign bus.mem_read   = mem_read   & ~reset;
  assign bus.mem_write  = mem_write  & ~reset;
  assign bus.ir_write   = ir_write   & ~reset;
  assign bus.mem_to_reg = mem_to_reg & ~reset;
  assign bus.reg_write  = reg_write  & ~reset;
  assign bus.alu_src_a  = alu_src_a  & ~reset;
  assign bus.alu_src_b  = reset ? 2'b00 : alu_src_b;
  assign bus.alu_op     = reset ? 2'b00 : alu_op;
  assign bus.halted     = halted_q   & ~reset;
endmodule
